mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single unified 19-bit-word memory between two requesters: the multicycle
//  control/datapath (CPU port, driven from MemRead/MemWrite/mem_select) and the program
//  loader (LDR port) that fills memory before and between runs. It serialises accesses,
//  sequences the fixed memory latency and returns a one-cycle ack per access.
//  Sits between control/datapath and the memory macro.
// PARAMETERS
//  DATA_W      19  memory word width
//  ADDR_W      8   memory address width
//  MEM_LAT     1   cycles from mem_en to valid mem_rdata; legal range >=1
//  LDR_PRIO    0   1 = loader has fixed priority; 0 = round-robin between ports
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  cpu_req    in   1       CPU access request; held until cpu_ack
//  cpu_we     in   1       1 = write, 0 = read; valid while cpu_req
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_wdata  in   DATA_W  CPU write data
//  cpu_rdata  out  DATA_W  CPU read data, registered
//  cpu_ack    out  1       one-cycle completion pulse
//  ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_rdata/ldr_ack  same as cpu_* for the loader
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
//  busy       out  1       1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0, including rdata registers. last_grant=LDR, so the CPU wins the first tie.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered or decoded from state only.
//   IDLE: if either req is high, pick the winner and latch its we/addr/wdata and the grant ID. Go to ISSUE.
//   ISSUE (1 cycle): mem_en=1, with mem_we/mem_addr/mem_wdata taken from the latched registers.
//     Load the down-counter with MEM_LAT-1.
//   WAIT (MEM_LAT cycles): decrement the counter. On the cycle the counter reaches 0, mem_rdata is valid.
//     On a read, capture mem_rdata into the winner's rdata register at the end of that cycle. Go to RESP.
//   RESP (1 cycle): winner's ack=1. Requests are ignored in RESP. Next state is IDLE.
//  Timing: req is sampled high at the end of IDLE cycle t. mem_en is high in t+1. ack is high in t+2+MEM_LAT.
//   The next grant can be sampled at t+3+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
//  Pick rule: with one req, that port wins.
//   With both reqs and LDR_PRIO=1, LDR wins.
//   With both reqs and LDR_PRIO=0, the port opposite last_grant wins.
//   last_grant updates on every grant.
//  rdata registers change only on reads completed for that port. Writes and the other port's reads leave them unchanged.
//  A requester must deassert req in the cycle after its ack, or keep it high to request again.
//  A req dropped before ack is a protocol violation. The access still completes and ack still pulses.
//  mem_addr, mem_wdata and mem_we hold their latched values outside ISSUE. Only mem_en qualifies them.
//  Reset mid-operation returns to IDLE on the next edge and drops the ack.
//   A write already issued in ISSUE may have landed in memory; this is accepted.
// STRUCTURE
//  Shared header mem_arb_defs.vh: state encodings (IDLE/ISSUE/WAIT/RESP, 2 bits), port IDs (PORT_CPU=0, PORT_LDR=1).
//  One sub-module, lat_counter: loadable down-counter, width $clog2(MEM_LAT+1), with a zero flag.
//  Everything else stays in mem_arbiter.
// TESTING (model memory with parameterised MEM_LAT; run with MEM_LAT=1 and MEM_LAT=3)
//  1 CPU read only: mem[0x30]=19'h00123, cpu_req, addr 0x30.
//    -> mem_en in t+1; cpu_ack=1 and cpu_rdata=19'h00123 in t+2+MEM_LAT; ldr_ack stays 0.
//  2 LDR write then CPU read: ldr writes 19'h07600 to 0x00, then cpu reads 0x00.
//    -> cpu_rdata=19'h07600; ldr_rdata unchanged (0).
//  3 Tie, LDR_PRIO=0, both reqs held for 4 accesses.
//    -> grant order CPU, LDR, CPU, LDR; acks are spaced MEM_LAT+3 cycles apart.
//  4 Tie, LDR_PRIO=1, both reqs held.
//    -> LDR wins every grant; CPU acks only after ldr_req drops.
//  5 Reset in WAIT during a CPU read: assert reset for 1 cycle.
//    -> busy=0 next cycle; no cpu_ack; cpu_rdata=0.
//    -> a subsequent read of 0x30 completes normally.
//  6 CPU drops req in ISSUE.
//    -> access completes and cpu_ack pulses once; no second mem_en.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU/loader memory arbiter: FSM states, port IDs and the
// grant pick rule.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PortCpu = 1'b0,
    PortLdr = 1'b1
  } port_e;

  // A lone requester always wins; a tie goes to the loader under fixed
  // priority, otherwise to the port that did not win last time.
  function automatic port_e pick_port(input logic  cpu_req,
                                      input logic  ldr_req,
                                      input logic  ldr_prio,
                                      input port_e last_grant);
    port_e win;
    if (cpu_req && ldr_req) begin
      if (ldr_prio) begin
        win = PortLdr;
      end else begin
        win = (last_grant == PortCpu) ? PortLdr : PortCpu;
      end
    end else if (ldr_req) begin
      win = PortLdr;
    end else begin
      win = PortCpu;
    end
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter that sequences the fixed memory latency; it saturates
// at zero and flags when it is there.
module mem_arbiter_lat_counter #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a fixed-latency single-port memory. Serialises
// CPU and loader accesses through IDLE -> ISSUE -> WAIT -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 19,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MEM_LAT  = 1,
  parameter bit          LDR_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  // Loader port
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  // Memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned     CntW    = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(MEM_LAT - 1);

  arb_state_e        state_q;
  port_e             grant_q;
  port_e             last_grant_q;
  port_e             win_port;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              cpu_ack_q;
  logic              ldr_ack_q;
  logic              busy_q;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  always_comb begin
    win_port = pick_port(cpu_req, ldr_req, LDR_PRIO, last_grant_q);
    cnt_load = (state_q == StIssue);
    cnt_dec  = (state_q == StWait);
  end

  mem_arbiter_lat_counter #(
    .Width (CntW)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CntLoad),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Strobes and busy are registered against the state being entered, so each
  // lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= PortCpu;
      last_grant_q <= PortLdr;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      ldr_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      ldr_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req || ldr_req) begin
            grant_q      <= win_port;
            last_grant_q <= win_port;
            if (win_port == PortLdr) begin
              mem_we_q    <= ldr_we;
              mem_addr_q  <= ldr_addr;
              mem_wdata_q <= ldr_wdata;
            end else begin
              mem_we_q    <= cpu_we;
              mem_addr_q  <= cpu_addr;
              mem_wdata_q <= cpu_wdata;
            end
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_zero) begin
            if (!mem_we_q) begin
              if (grant_q == PortLdr) begin
                ldr_rdata_q <= mem_rdata;
              end else begin
                cpu_rdata_q <= mem_rdata;
              end
            end
            cpu_ack_q <= (grant_q == PortCpu);
            ldr_ack_q <= (grant_q == PortLdr);
            state_q   <= StResp;
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two configurations (MEM_LAT=3 round-robin, MEM_LAT=1
// loader priority), each with directed cases and random traffic vs a timeline model.
module tb_mem_arbiter;

  localparam int unsigned DW = 19;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 'h30) return 19'h00123;
    return 19'((a * 32'h1357) ^ 32'h2A5A5);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int unsigned L = (g == 0) ? 3 : 1;
    localparam bit          P = (g == 0) ? 1'b0 : 1'b1;

    logic          reset, mem_init;
    logic          cpu_req, cpu_we, cpu_ack, ldr_req, ldr_we, ldr_ack;
    logic [AW-1:0] cpu_addr, ldr_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata, ldr_wdata, ldr_rdata, mem_wdata, mem_rdata;
    logic          mem_en, mem_we, busy;

    mem_arbiter #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .MEM_LAT  (L),
      .LDR_PRIO (P)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .ldr_req   (ldr_req),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_rdata (ldr_rdata),
      .ldr_ack   (ldr_ack),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    // Memory macro: read data valid L cycles after the mem_en cycle, noise otherwise.
    logic [DW-1:0] env_mem [256];
    logic [DW-1:0] rd_pipe [L];
    always @(posedge clk) begin
      if (mem_init) begin
        for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
      end else if (mem_en && mem_we) begin
        env_mem[mem_addr] <= mem_wdata;
      end
      rd_pipe[0] <= mem_en ? env_mem[mem_addr] : DW'($urandom);
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[L-1];

    // Reference model: one access timeline plus its own memory and rdata copies.
    int            cyc, en_c, ack_c, free_c, en_seen;
    bit            m_act, m_win, m_we, m_last, cpu_acked, ldr_acked, fin;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd, m_cpu_rd, m_ldr_rd;
    logic [DW-1:0] ref_mem [256];
    int            ack_cyc_q [$];
    bit            ack_port_q [$];

    task automatic sample();
      bit e_en, e_busy, e_cack, e_lack;
      if (m_act && cyc >= free_c) m_act = 1'b0;
      e_busy = m_act && (cyc >= en_c);
      e_en   = m_act && (cyc == en_c);
      e_cack = m_act && (cyc == ack_c) && !m_win;
      e_lack = m_act && (cyc == ack_c) && m_win;
      if (e_en) begin
        if (m_we) ref_mem[m_addr] = m_wd;
        else m_rd = ref_mem[m_addr];
        check_eq($sformatf("g%0d mem_addr", g), 32'(mem_addr), 32'(m_addr));
        check_eq($sformatf("g%0d mem_we", g), 32'(mem_we), 32'(m_we));
        if (m_we) check_eq($sformatf("g%0d mem_wdata", g), 32'(mem_wdata), 32'(m_wd));
      end
      if (e_cack && !m_we) m_cpu_rd = m_rd;
      if (e_lack && !m_we) m_ldr_rd = m_rd;
      check_eq($sformatf("g%0d ctl@%0d {busy,en,cack,lack}", g, cyc),
               32'({busy, mem_en, cpu_ack, ldr_ack}), 32'({e_busy, e_en, e_cack, e_lack}));
      check_eq($sformatf("g%0d cpu_rdata@%0d", g, cyc), 32'(cpu_rdata), 32'(m_cpu_rd));
      check_eq($sformatf("g%0d ldr_rdata@%0d", g, cyc), 32'(ldr_rdata), 32'(m_ldr_rd));
      if (mem_en) en_seen++;
      if (cpu_ack) begin ack_cyc_q.push_back(cyc); ack_port_q.push_back(1'b0); end
      if (ldr_ack) begin ack_cyc_q.push_back(cyc); ack_port_q.push_back(1'b1); end
      cpu_acked = e_cack;
      ldr_acked = e_lack;
      if (reset) begin
        m_act = 1'b0; m_last = 1'b1; m_cpu_rd = '0; m_ldr_rd = '0;
      end else if (!m_act && (cpu_req || ldr_req)) begin
        if (cpu_req && ldr_req) m_win = P ? 1'b1 : !m_last;
        else m_win = ldr_req;
        m_last = m_win;
        m_we   = m_win ? ldr_we : cpu_we;
        m_addr = m_win ? ldr_addr : cpu_addr;
        m_wd   = m_win ? ldr_wdata : cpu_wdata;
        en_c   = cyc + 1;
        ack_c  = cyc + 2 + L;
        free_c = cyc + 3 + L;
        m_act  = 1'b1;
      end
    endtask

    task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      cyc++;
    endtask

    task automatic access(input bit port, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      if (port) begin ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d; end
      else begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      for (int k = 0; k < 40; k++) begin
        step();
        if (port ? ldr_acked : cpu_acked) break;
      end
      if (port) ldr_req = 0; else cpu_req = 0;
    endtask

    task automatic do_reset();
      reset = 1;
      step();
      reset = 0;
    endtask

    initial begin
      int nl, na, ens, acks;
      bit exp_ord [4];
      fin = 0; reset = 1; mem_init = 1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      m_act = 0; m_last = 1; m_cpu_rd = '0; m_ldr_rd = '0; m_rd = '0;
      cyc = 0; en_seen = 0; cpu_acked = 0; ldr_acked = 0;
      @(posedge clk); #1;
      mem_init = 0;
      check_eq($sformatf("g%0d reset outs", g),
               32'({busy, mem_en, mem_we, cpu_ack, ldr_ack}), 32'd0);
      check_eq($sformatf("g%0d reset mem_addr/wdata", g), 32'({mem_addr, mem_wdata}), 32'd0);
      check_eq($sformatf("g%0d reset rdata", g), 32'(cpu_rdata | ldr_rdata), 32'd0);
      step();
      reset = 0;

      // CPU read alone
      access(0, 0, 8'h30, '0);
      check_eq($sformatf("g%0d t1 cpu_rdata", g), 32'(cpu_rdata), 32'h00123);
      check_eq($sformatf("g%0d t1 ldr acks", g), 32'(ack_port_q.sum() with (32'(item))), 32'd0);

      // Loader write then CPU read back
      access(1, 1, 8'h00, 19'h07600);
      access(0, 0, 8'h00, '0);
      check_eq($sformatf("g%0d t2 cpu_rdata", g), 32'(cpu_rdata), 32'h07600);
      check_eq($sformatf("g%0d t2 ldr_rdata", g), 32'(ldr_rdata), 32'd0);

      // Tie with both requests held
      do_reset();
      ack_port_q.delete(); ack_cyc_q.delete();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
      ldr_req = 1; ldr_we = 0; ldr_addr = 8'h05;
      nl = 0; na = 0;
      for (int k = 0; k < 80 && na < 4; k++) begin
        step();
        if (cpu_acked || ldr_acked) na++;
        if (ldr_acked) begin
          nl++;
          if (P && nl == 3) ldr_req = 0;
        end
      end
      cpu_req = 0; ldr_req = 0;
      if (P) exp_ord = '{1'b1, 1'b1, 1'b1, 1'b0};
      else exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
      check_eq($sformatf("g%0d tie ack count", g), 32'(ack_port_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < ack_port_q.size(); i++)
        check_eq($sformatf("g%0d tie grant %0d", g, i), 32'(ack_port_q[i]), 32'(exp_ord[i]));
      for (int i = 1; i < 4 && i < ack_cyc_q.size(); i++)
        check_eq($sformatf("g%0d tie spacing %0d", g, i),
                 32'(ack_cyc_q[i] - ack_cyc_q[i-1]), 32'(L + 3));

      // Reset during WAIT of a CPU read
      step();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h30;
      for (int k = 0; k < 20; k++) begin
        step();
        if (m_act && cyc == en_c + 1) break;
      end
      acks = ack_port_q.size();
      reset = 1; cpu_req = 0;
      step();
      reset = 0;
      check_eq($sformatf("g%0d t5 busy", g), 32'(busy), 32'd0);
      check_eq($sformatf("g%0d t5 cpu_rdata", g), 32'(cpu_rdata), 32'd0);
      step();
      check_eq($sformatf("g%0d t5 no ack", g), 32'(ack_port_q.size() - acks), 32'd0);
      access(0, 0, 8'h30, '0);
      check_eq($sformatf("g%0d t5 reread", g), 32'(cpu_rdata), 32'h00123);

      // CPU drops request during ISSUE
      step();
      ens = en_seen; acks = ack_port_q.size();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
      for (int k = 0; k < 20; k++) begin
        step();
        if (m_act && cyc == en_c) break;
      end
      cpu_req = 0;
      for (int k = 0; k < int'(L) + 5; k++) step();
      check_eq($sformatf("g%0d t6 mem_en count", g), 32'(en_seen - ens), 32'd1);
      check_eq($sformatf("g%0d t6 ack count", g), 32'(ack_port_q.size() - acks), 32'd1);

      // Random traffic from both requesters
      for (int k = 0; k < 600; k++) begin
        if (cpu_acked ? ($urandom_range(1) == 1) : (!cpu_req && $urandom_range(2) == 0)) begin
          cpu_req = 1; cpu_we = $urandom_range(1) == 1;
          cpu_addr = AW'($urandom_range(15)); cpu_wdata = DW'($urandom);
        end else if (cpu_acked) begin
          cpu_req = 0;
        end
        if (ldr_acked ? ($urandom_range(1) == 1) : (!ldr_req && $urandom_range(2) == 0)) begin
          ldr_req = 1; ldr_we = $urandom_range(1) == 1;
          ldr_addr = AW'($urandom_range(15)); ldr_wdata = DW'($urandom);
        end else if (ldr_acked) begin
          ldr_req = 0;
        end
        step();
      end
      cpu_req = 0; ldr_req = 0;
      for (int k = 0; k < int'(L) + 5; k++) step();
      fin = 1;
    end
  end

  initial begin
    for (int k = 0; k < 20000 && !(cfg[0].fin && cfg[1].fin); k++) @(posedge clk);
    check_eq("both configs finished", 32'({cfg[0].fin, cfg[1].fin}), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
